// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between instruction fetch and the load/store buffer for one 8-bit memory port.
// Define MEM_ARB_RR_EN for round-robin priority on ties; the default is fixed LSB-over-fetch priority.
module mem_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  lsb_req,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_size,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata,
    input  logic                  flush,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    typedef enum logic [2:0] {IDLE, IF_RD, LSB_RD, LSB_WR, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_done_q, if_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic                  lsb_done_q, lsb_done_d;
    logic [31:0]           lsb_rdata_q, lsb_rdata_d;
`ifdef MEM_ARB_RR_EN
    logic                  last_grant_q, last_grant_d;
`endif

    logic       if_ok;
    logic       grant_lsb;
    logic       grant_if;
    logic       io_stall;
    logic [2:0] idx_next;
    logic [1:0] cap_sel;
    logic [1:0] wr_sel;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign if_ok = if_req && !flush;
`ifdef MEM_ARB_RR_EN
    // last_grant_q high means fetch won last, so LSB takes the next tie.
    assign grant_lsb = lsb_req && (!if_ok || last_grant_q);
`else
    assign grant_lsb = lsb_req;
`endif
    assign grant_if = if_ok && !grant_lsb;
    assign io_stall = io_buffer_full && (mem_a_q >= IO_BASE);
    assign idx_next = idx_q + 3'd1;
    assign cap_sel  = 2'(idx_q - 3'd1);
    assign wr_sel   = 2'(idx_next);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nbytes_d    = nbytes_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        lsb_done_d  = 1'b0;
        lsb_rdata_d = lsb_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                idx_d      = 3'd0;
                data_d     = '0;
                mem_a_d    = '0;
                mem_wr_d   = 1'b0;
                mem_dout_d = '0;
                if (grant_lsb) begin
                    addr_d   = lsb_addr;
                    wdata_d  = lsb_wdata;
                    nbytes_d = size_to_bytes(lsb_size);
                    mem_a_d  = lsb_addr;
                    if (lsb_wr) begin
                        state_d    = LSB_WR;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = lsb_wdata[7:0];
                    end else begin
                        state_d = LSB_RD;
                    end
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end else if (grant_if) begin
                    addr_d   = if_addr;
                    nbytes_d = 3'd4;
                    mem_a_d  = if_addr;
                    state_d  = IF_RD;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end
            end
            IF_RD, LSB_RD: begin
                if (state_q == IF_RD && flush) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    mem_a_d = '0;
                end else begin
                    // idx counts addresses issued; the byte on mem_din belongs to idx-1.
                    if (idx_q != 3'd0) begin
                        data_d[{cap_sel, 3'b000} +: 8] = mem_din;
                    end
                    if (idx_q == nbytes_q) begin
                        state_d = DONE;
                        mem_a_d = '0;
                        if (state_q == IF_RD) begin
                            if_done_d = 1'b1;
                            if_data_d = data_d;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = data_d;
                        end
                    end else begin
                        idx_d   = idx_next;
                        mem_a_d = (idx_next < nbytes_q) ? addr_q + ADDR_WIDTH'(idx_next) : '0;
                    end
                end
            end
            LSB_WR: begin
                if (!io_stall) begin
                    if (idx_next == nbytes_q) begin
                        state_d    = DONE;
                        lsb_done_d = 1'b1;
                        mem_wr_d   = 1'b0;
                        mem_a_d    = '0;
                        mem_dout_d = '0;
                    end else begin
                        idx_d      = idx_next;
                        mem_a_d    = addr_q + ADDR_WIDTH'(idx_next);
                        mem_dout_d = wdata_q[{wr_sel, 3'b000} +: 8];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                mem_a_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else if (rdy_in) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nbytes_q    <= nbytes_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // A stalled IO byte or a frozen pipeline must never strobe the bus.
    assign mem_wr    = mem_wr_q && rdy_in && !io_stall;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign if_done   = if_done_q && !flush;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: transaction table plus cycle-accurate corner-case sequences.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        flush;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:4095];
    logic [7:0] io_byte;
    int         io_writes;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.ADDR_WIDTH(32), .IO_BASE(32'h30000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // Byte-wide RAM with one cycle read latency; IO space writes go to a log instead.
    always @(posedge clk_in) begin
        if (!rst_in) begin
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05; ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h00;
            ram[12'h020] <= 8'hAB;
            ram[12'h050] <= 8'h11; ram[12'h051] <= 8'h22; ram[12'h052] <= 8'h33; ram[12'h053] <= 8'h44;
            ram[12'h062] <= 8'h00; ram[12'h063] <= 8'h00; ram[12'h071] <= 8'h00;
            io_writes <= 0;
            io_byte   <= 8'h00;
            mem_din   <= 8'h00;
        end else if (rdy_in) begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) begin
                if (mem_a >= 32'h30000) begin
                    io_byte   <= mem_dout;
                    io_writes <= io_writes + 1;
                end else begin
                    ram[mem_a[11:0]] <= mem_dout;
                end
            end
        end
    end

    typedef struct {
        string       name;
        logic        is_lsb;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    function automatic vec_t make_vec(input string name, input logic is_lsb, input logic wr,
                                      input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic chk_data,
                                      input logic [31:0] exp_data, input int exp_lat);
        vec_t v;
        v.name = name; v.is_lsb = is_lsb; v.wr = wr; v.size = size; v.addr = addr;
        v.wdata = wdata; v.chk_data = chk_data; v.exp_data = exp_data; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.is_lsb) begin
            lsb_req   = 1'b1;
            lsb_wr    = v.wr;
            lsb_size  = v.size;
            lsb_addr  = v.addr;
            lsb_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
    endtask

    task automatic release_requests();
        if_req  = 1'b0;
        lsb_req = 1'b0;
        lsb_wr  = 1'b0;
    endtask

    vec_t        vecs [10];
    logic [7:0]  wr_bytes [4];
    int          lat;
    logic [31:0] got;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = '0; lsb_wdata = '0;

        vecs[0] = make_vec("tbl fetch 0x100",  1'b0, 1'b0, 2'b10, 32'h100, 32'h0,        1'b1, 32'h00000513, 6);
        vecs[1] = make_vec("tbl rd byte 0x20", 1'b1, 1'b0, 2'b00, 32'h020, 32'h0,        1'b1, 32'h000000AB, 3);
        vecs[2] = make_vec("tbl rd half 0x52", 1'b1, 1'b0, 2'b01, 32'h052, 32'h0,        1'b1, 32'h00004433, 4);
        vecs[3] = make_vec("tbl rd word 0x50", 1'b1, 1'b0, 2'b10, 32'h050, 32'h0,        1'b1, 32'h44332211, 6);
        vecs[4] = make_vec("tbl wr half 0x60", 1'b1, 1'b1, 2'b01, 32'h060, 32'hCAFE1234, 1'b0, 32'h0,        3);
        vecs[5] = make_vec("tbl rd sz3 0x60",  1'b1, 1'b0, 2'b11, 32'h060, 32'h0,        1'b1, 32'h00001234, 6);
        vecs[6] = make_vec("tbl fetch 0x50",   1'b0, 1'b0, 2'b10, 32'h050, 32'h0,        1'b1, 32'h44332211, 6);
        vecs[7] = make_vec("tbl wr byte 0x70", 1'b1, 1'b1, 2'b00, 32'h070, 32'h0000009C, 1'b0, 32'h0,        2);
        vecs[8] = make_vec("tbl rd half 0x70", 1'b1, 1'b0, 2'b01, 32'h070, 32'h0,        1'b1, 32'h0000009C, 4);
        vecs[9] = make_vec("tbl wr word 0x60", 1'b1, 1'b1, 2'b10, 32'h060, 32'h01020304, 1'b0, 32'h0,        5);

        // Reset state
        step(); step(); step();
        check_output("reset mem_a", mem_a, 32'h0);
        check_output("reset mem_wr", {31'b0, mem_wr}, 32'h0);
        check_output("reset dones", {30'b0, if_done, lsb_done}, 32'h0);
        check_output("reset if_data", if_data, 32'h0);
        check_output("reset lsb_rdata", lsb_rdata, 32'h0);
        rst_in = 1'b1;
        step();

        // Transaction table: latency from acceptance cycle and returned data
        for (int t = 0; t < 10; t++) begin
            apply_stimulus(vecs[t]);
            lat = 0;
            got = '0;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (vecs[t].is_lsb ? lsb_done : if_done) begin
                    lat = k;
                    got = vecs[t].is_lsb ? lsb_rdata : if_data;
                    break;
                end
            end
            release_requests();
            check_output({vecs[t].name, " latency"}, lat, vecs[t].exp_lat);
            if (vecs[t].chk_data) check_output({vecs[t].name, " data"}, got, vecs[t].exp_data);
            step();
        end
        check_output("ram 0x63 after word write", {24'b0, ram[12'h063]}, 32'h01);

        // Fetch address stepping
        if_req = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output($sformatf("fetch mem_a cycle %0d", i + 1), mem_a, 32'h100 + i);
            check_output($sformatf("fetch no done cycle %0d", i + 1), {31'b0, if_done}, 32'h0);
        end
        step();
        check_output("fetch no done cycle 5", {31'b0, if_done}, 32'h0);
        step();
        check_output("fetch done cycle 6", {31'b0, if_done}, 32'h1);
        check_output("fetch data", if_data, 32'h00000513);
        release_requests();
        step();

        // Simultaneous requests: LSB first, fetch in the next IDLE cycle
        if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h20;
        step();
        check_output("tie lsb granted mem_a", mem_a, 32'h20);
        step(); step();
        check_output("tie lsb_done cycle 3", {31'b0, lsb_done}, 32'h1);
        check_output("tie lsb_rdata", lsb_rdata, 32'h000000AB);
        lsb_req = 1'b0;
        step();
        check_output("tie idle mem_a", mem_a, 32'h0);
        step();
        check_output("tie fetch granted mem_a", mem_a, 32'h100);
        lat = 0;
        for (int k = 6; k <= 20; k++) begin
            step();
            if (if_done) begin lat = k; break; end
        end
        check_output("tie fetch done cycle", lat, 10);
        check_output("tie fetch data", if_data, 32'h00000513);
        release_requests();
        step();

        // Word write byte order
        wr_bytes[0] = 8'hEF; wr_bytes[1] = 8'hBE; wr_bytes[2] = 8'hAD; wr_bytes[3] = 8'hDE;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h40; lsb_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output($sformatf("wr mem_wr cycle %0d", i + 1), {31'b0, mem_wr}, 32'h1);
            check_output($sformatf("wr mem_a cycle %0d", i + 1), mem_a, 32'h40 + i);
            check_output($sformatf("wr mem_dout cycle %0d", i + 1), {24'b0, mem_dout}, {24'b0, wr_bytes[i]});
        end
        step();
        check_output("wr lsb_done cycle 5", {31'b0, lsb_done}, 32'h1);
        check_output("wr mem_wr off cycle 5", {31'b0, mem_wr}, 32'h0);
        release_requests();
        step();
        check_output("ram 0x40", {24'b0, ram[12'h040]}, 32'hEF);
        check_output("ram 0x43", {24'b0, ram[12'h043]}, 32'hDE);

        // IO write held off by io_buffer_full
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h0000005A;
        io_buffer_full = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            check_output($sformatf("io stall mem_wr cycle %0d", c), {31'b0, mem_wr}, 32'h0);
            check_output($sformatf("io stall lsb_done cycle %0d", c), {31'b0, lsb_done}, 32'h0);
        end
        step();
        io_buffer_full = 1'b0;
        #1;
        check_output("io issue mem_wr", {31'b0, mem_wr}, 32'h1);
        check_output("io issue mem_a", mem_a, 32'h30000);
        check_output("io issue mem_dout", {24'b0, mem_dout}, 32'h5A);
        step();
        check_output("io lsb_done", {31'b0, lsb_done}, 32'h1);
        check_output("io write count", io_writes, 1);
        check_output("io byte", {24'b0, io_byte}, 32'h5A);
        release_requests();
        step();

        // Flush aborts a fetch; the pending LSB read follows
        if_req = 1'b1; if_addr = 32'h100;
        step();
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h20;
        step(); step();
        flush = 1'b1; if_req = 1'b0;
        #1;
        check_output("flush no if_done cycle 3", {31'b0, if_done}, 32'h0);
        step();
        flush = 1'b0;
        check_output("flush idle mem_a", mem_a, 32'h0);
        step();
        check_output("flush lsb granted mem_a", mem_a, 32'h20);
        step(); step();
        check_output("flush lsb_done", {31'b0, lsb_done}, 32'h1);
        check_output("flush lsb_rdata", lsb_rdata, 32'h000000AB);
        check_output("flush no if_done later", {31'b0, if_done}, 32'h0);
        release_requests();
        step();

        // rdy_in low freezes a fetch for three cycles
        if_req = 1'b1; if_addr = 32'h50;
        step();
        check_output("rdy mem_a cycle 1", mem_a, 32'h50);
        step();
        rdy_in = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            check_output($sformatf("rdy frozen mem_a cycle %0d", c), mem_a, 32'h51);
            if (c < 4) step();
        end
        step();
        rdy_in = 1'b1;
        step(); step();
        step();
        check_output("rdy no done cycle 8", {31'b0, if_done}, 32'h0);
        step();
        check_output("rdy done cycle 9", {31'b0, if_done}, 32'h1);
        check_output("rdy fetch data", if_data, 32'h44332211);
        release_requests();
        step();

        // Reset in the middle of a word write
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h80; lsb_wdata = 32'h11223344;
        step();
        check_output("rst wr active cycle 1", {31'b0, mem_wr}, 32'h1);
        step();
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        release_requests();
        check_output("rst mem_wr", {31'b0, mem_wr}, 32'h0);
        check_output("rst mem_a", mem_a, 32'h0);
        check_output("rst mem_dout", {24'b0, mem_dout}, 32'h0);
        check_output("rst dones", {30'b0, if_done, lsb_done}, 32'h0);
        check_output("rst lsb_rdata", lsb_rdata, 32'h0);
        check_output("rst if_data", if_data, 32'h0);
        step();
        check_output("rst no lsb_done after", {31'b0, lsb_done}, 32'h0);
        check_output("rst no mem_wr after", {31'b0, mem_wr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/IO port between two requesters: instruction fetch (32-bit word reads) and the load/store buffer (1/2/4-byte reads and writes).
- Performs the multi-byte address stepping and little-endian byte assembly/disassembly.
- Owns arbitration, flush abort of fetches and IO write back-pressure.
- Sits between ifetch/LSB and the top-level memory bus (mem_a/mem_dout/mem_din/mem_wr).

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO space; IO writes obey io_buffer_full.

Ports:
- clk_in  input  1  single clock; all state on rising edge.
- rst_in  input  1  reset; synchronous, active-low.
- rdy_in  input  1  global ready; low freezes the block.
- if_req  input  1  fetch request, level, held until if_done.
- if_addr  input  ADDR_WIDTH  fetch word address.
- if_done  output  1  one-cycle pulse; if_data valid.
- if_data  output  32  fetched word, little-endian.
- lsb_req  input  1  LSB request, level, held until lsb_done.
- lsb_wr  input  1  1 = write, 0 = read.
- lsb_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- lsb_addr  input  ADDR_WIDTH  start byte address.
- lsb_wdata  input  32  write data; low N bytes used.
- lsb_done  output  1  one-cycle pulse; read data valid or write complete.
- lsb_rdata  output  32  read data, zero-extended above N bytes.
- flush  input  1  misprediction; aborts an in-flight fetch.
- io_buffer_full  input  1  IO sink cannot accept a byte.
- mem_din  input  8  RAM/IO read byte; valid one cycle after its address.
- mem_dout  output  8  write byte.
- mem_a  output  ADDR_WIDTH  byte address.
- mem_wr  output  1  1 = write this cycle.

Behaviour:
- Reset (rst_in low at an edge), including mid-operation:
  - state IDLE, counters 0, mem_a=0, mem_dout=0, mem_wr=0.
  - if_done=lsb_done=0, if_data=lsb_rdata=0.
  - The transfer in progress is abandoned and no done is issued.
- States: IDLE, IF_RD, LSB_RD, LSB_WR, DONE. Registered outputs; 3-bit byte counter idx; N = number of bytes (4 for fetch).
- IDLE:
  - Samples requests; flush in the same cycle suppresses if_req.
  - Grant (acceptance edge = cycle 0) latches address, size, wdata and requester.
  - Fixed priority: LSB over fetch.
  - With no request: mem_a=0, mem_wr=0.
- Read (IF_RD/LSB_RD):
  - mem_a = A+i in cycle i+1, i = 0..N-1.
  - Byte i is captured from mem_din at the end of cycle i+2 into bits [8i+7:8i].
  - DONE occupies cycle N+2: done is high for exactly that cycle with data valid.
  - Latency: 4-byte read = 6 cycles from acceptance to done; byte read = 3 cycles.
- Write (LSB_WR):
  - mem_a = A+i, mem_dout = wdata[8i+7:8i], mem_wr = 1 in cycle i+1.
  - lsb_done in cycle N+1.
- IO back-pressure:
  - Applies when the target address >= IO_BASE and io_buffer_full is high.
  - The byte is not issued: mem_wr=0, idx holds, and the byte retries each cycle until io_buffer_full is low.
  - IO reads are not stalled.
- Flush:
  - High in any IF_RD cycle: next state is IDLE, no if_done, mem_a=0.
  - Flush in the DONE cycle of a fetch suppresses if_done.
  - LSB transfers are never aborted by flush.
- DONE always returns to IDLE. The requester must drop req by the edge on which it samples done; a new grant is possible in the IDLE cycle after DONE.
- rdy_in low: all registers hold, mem_wr forced 0. The memory side is also halted, so capture resumes unchanged when rdy_in returns high.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no alignment checks.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- When defined: round-robin priority. A last_grant bit flips on each grant. When both requests are present in IDLE, the requester not granted last wins. Reset sets last_grant so that LSB wins the first tie.
- When undefined: fixed LSB-over-fetch priority, and the last_grant register is absent.

Test Plan:
- Fetch only: if_addr=0x100, RAM bytes 13,05,00,00 at 0x100..0x103. Required: mem_a steps 0x100..0x103 in cycles 1..4; if_done pulses in cycle 6; if_data=0x00000513.
- Simultaneous if_req and lsb_req (byte read at 0x20 = 0xAB). Required: LSB is granted first; lsb_rdata=0x000000AB at cycle 3; fetch is granted in the following IDLE cycle. With MEM_ARB_RR_EN on a second tie, fetch wins.
- LSB word write 0xDEADBEEF to 0x40. Required: mem_wr=1 for 4 cycles carrying EF,BE,AD,DE at 0x40..0x43; lsb_done in cycle 5.
- IO byte write to 0x30000 with io_buffer_full high for 3 cycles. Required: mem_wr stays 0 for those 3 cycles; byte issued on the first low cycle; lsb_done the cycle after.
- Flush asserted in cycle 3 of a fetch. Required: IDLE next cycle, no if_done. A pending LSB read is granted afterwards and completes normally.
- rst_in pulsed low in cycle 2 of a word write. Required: mem_wr=0 from the next cycle, no lsb_done, all outputs 0.
